// File: rtl/eeg_pkg.sv
// ----------------------------------------------------------------------------
// eeg_pkg
// Shared definitions for the EarEEG nibble packer and its sample FIFO.
//   SAMPLE_W / NIB_W  : sample and nibble widths
//   DEF_NUM_CH        : default channels (samples) per frame
//   DEF_FIFO_DEPTH    : default sample FIFO depth
//   pk_state_e        : packer FSM states
//   sample_t          : {ch, data} record of one completed sample; ch is
//                       sized for the largest supported frame (16 channels)
// ----------------------------------------------------------------------------
package eeg_pkg;

  localparam int SAMPLE_W       = 16;
  localparam int NIB_W          = 4;
  localparam int NIBS_PER_WORD  = SAMPLE_W / NIB_W;
  localparam int MAX_CH_W       = 4;

  localparam int DEF_NUM_CH     = 8;
  localparam int DEF_FIFO_DEPTH = 16;

  typedef enum logic {
    IDLE,
    COLLECT
  } pk_state_e;

  typedef struct packed {
    logic [MAX_CH_W-1:0] ch;
    logic [SAMPLE_W-1:0] data;
  } sample_t;

endpackage : eeg_pkg

// File: rtl/eeg_sync_fifo.sv
// ----------------------------------------------------------------------------
// eeg_sync_fifo
// Single-clock first-word-fall-through FIFO. The head entry is presented on
// pop_data whenever the FIFO is not empty; pop_data reads 0 while empty.
// A push while full is accepted only if a pop happens in the same cycle.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   push, push_data   write request and data
//   pop               read request (ignored while empty)
//   pop_data          head entry
//   full, empty       occupancy status
//   level             current occupancy, 0..DEPTH
// ----------------------------------------------------------------------------
module eeg_sync_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level_q == '0);
  assign full    = (level_q == LVL_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // At full, the slot being written is the one being popped this cycle.
  assign do_push = push && (!full || do_pop);

  assign pop_data = empty ? '0 : mem_q[rd_ptr_q];
  assign level    = level_q;

  // NOTE: storage is not reset; pointers and level define validity, so reset
  // empties the FIFO without a wide reset tree on the array.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule : eeg_sync_fifo

// File: rtl/eeg_nibble_packer.sv
// ----------------------------------------------------------------------------
// eeg_nibble_packer
// Assembles groups of four deserializer nibbles (MSB first) into 16-bit
// samples tagged with their channel index, and queues them in a FWFT FIFO
// drained by a valid/ready consumer. Reports framing errors and dropped
// samples as sticky flags.
// Ports:
//   data_clk, rst_n   clock, synchronous active-low reset
//   frame_start       pulse: start (or restart) a frame
//   nib_in, nib_valid completed nibble and its strobe
//   word_data/ch      head-of-FIFO sample and its channel
//   word_valid        FIFO not empty
//   word_ready        consumer accepts the head
//   fifo_level        FIFO occupancy
//   frame_err         sticky: frame restarted before completing
//   overflow          sticky: a completed sample was dropped
//   clr_flags         clears both sticky flags (a same-cycle set wins)
// ----------------------------------------------------------------------------
module eeg_nibble_packer
  import eeg_pkg::*;
#(
  parameter int  NUM_CH     = DEF_NUM_CH,
  parameter int  FIFO_DEPTH = DEF_FIFO_DEPTH,
  localparam int CH_W       = $clog2(NUM_CH),
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                data_clk,
  input  logic                rst_n,
  input  logic                frame_start,
  input  logic [NIB_W-1:0]    nib_in,
  input  logic                nib_valid,
  output logic [SAMPLE_W-1:0] word_data,
  output logic [CH_W-1:0]     word_ch,
  output logic                word_valid,
  input  logic                word_ready,
  output logic [LVL_W-1:0]    fifo_level,
  output logic                frame_err,
  output logic                overflow,
  input  logic                clr_flags
);

  localparam int REC_W = CH_W + SAMPLE_W;
  // Only the first three nibbles need storage; the fourth is taken straight
  // from nib_in when the word is pushed.
  localparam int SR_W  = SAMPLE_W - NIB_W;

  pk_state_e        state_q,   state_d;
  logic [1:0]       nib_cnt_q, nib_cnt_d;
  logic [CH_W-1:0]  ch_cnt_q,  ch_cnt_d;
  logic [SR_W-1:0]  sr_q,      sr_d;
  logic             frame_err_q;
  logic             overflow_q;

  logic             push_req;
  logic             ferr_set;
  logic             ovf_set;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [REC_W-1:0] push_rec;
  logic [REC_W-1:0] head_rec;

  // --------------------------------------------------------------------------
  // FSM, counters and shift register: next state
  // --------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first, so no path can leave
  // a signal unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    nib_cnt_d = nib_cnt_q;
    ch_cnt_d  = ch_cnt_q;
    sr_d      = sr_q;
    push_req  = 1'b0;
    ferr_set  = 1'b0;

    if (frame_start) begin
      // frame_start beats a coincident nib_valid; that nibble is discarded.
      ferr_set  = (state_q == COLLECT);
      state_d   = COLLECT;
      nib_cnt_d = '0;
      ch_cnt_d  = '0;
      sr_d      = '0;
    end else if (state_q == COLLECT && nib_valid) begin
      sr_d      = {sr_q[SR_W-NIB_W-1:0], nib_in};
      nib_cnt_d = nib_cnt_q + 1'b1;
      if (nib_cnt_q == 2'(NIBS_PER_WORD - 1)) begin
        push_req = 1'b1;
        ch_cnt_d = ch_cnt_q + 1'b1;
        if (ch_cnt_q == CH_W'(NUM_CH - 1)) begin
          state_d = IDLE;
        end
      end
    end
  end

  always_ff @(posedge data_clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      nib_cnt_q <= '0;
      ch_cnt_q  <= '0;
      sr_q      <= '0;
    end else begin
      state_q   <= state_d;
      nib_cnt_q <= nib_cnt_d;
      ch_cnt_q  <= ch_cnt_d;
      sr_q      <= sr_d;
    end
  end

  // --------------------------------------------------------------------------
  // Sample FIFO
  // --------------------------------------------------------------------------
  assign push_rec = {ch_cnt_q, sr_q, nib_in};
  assign pop      = word_valid && word_ready;
  // A push at full survives only when the consumer frees the head slot in
  // the same cycle; the channel count advances either way.
  assign ovf_set  = push_req && fifo_full && !pop;

  eeg_sync_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (data_clk),
    .rst_n     (rst_n),
    .push      (push_req),
    .push_data (push_rec),
    .pop       (pop),
    .pop_data  (head_rec),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign word_valid = !fifo_empty;
  assign word_data  = head_rec[SAMPLE_W-1:0];
  assign word_ch    = head_rec[SAMPLE_W +: CH_W];

  // --------------------------------------------------------------------------
  // Sticky flags: a set condition outranks a same-cycle clear
  // --------------------------------------------------------------------------
  always_ff @(posedge data_clk) begin
    if (!rst_n) begin
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      if (ferr_set)       frame_err_q <= 1'b1;
      else if (clr_flags) frame_err_q <= 1'b0;

      if (ovf_set)        overflow_q  <= 1'b1;
      else if (clr_flags) overflow_q  <= 1'b0;
    end
  end

  assign frame_err = frame_err_q;
  assign overflow  = overflow_q;

endmodule : eeg_nibble_packer

// File: tb/tb_eeg_nibble_packer.sv
// ----------------------------------------------------------------------------
// tb_eeg_nibble_packer
// Directed and random stimulus against a queue-based reference model of the
// packer (NUM_CH=8, FIFO_DEPTH=4). Outputs are compared mid-cycle before each
// clock edge, plus directed spot checks just after selected edges.
// ----------------------------------------------------------------------------
module tb_eeg_nibble_packer;
  import eeg_pkg::*;

  localparam int NUM_CH     = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int CH_W       = 3;
  localparam int LVL_W      = 3;

  logic              data_clk = 1'b0;
  logic              rst_n;
  logic              frame_start;
  logic [3:0]        nib_in;
  logic              nib_valid;
  logic [15:0]       word_data;
  logic [CH_W-1:0]   word_ch;
  logic              word_valid;
  logic              word_ready;
  logic [LVL_W-1:0]  fifo_level;
  logic              frame_err;
  logic              overflow;
  logic              clr_flags;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state
  sample_t mq[$];       // expected FIFO contents, head first
  int      m_nibs[$];   // nibbles of the word being assembled
  bit      m_active;    // inside a frame
  int      m_ch;        // channel of the word being assembled
  bit      m_ferr;
  bit      m_ovf;

  eeg_nibble_packer #(
    .NUM_CH     (NUM_CH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .data_clk    (data_clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .nib_in      (nib_in),
    .nib_valid   (nib_valid),
    .word_data   (word_data),
    .word_ch     (word_ch),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .fifo_level  (fifo_level),
    .frame_err   (frame_err),
    .overflow    (overflow),
    .clr_flags   (clr_flags)
  );

  always #5 data_clk = ~data_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    frame_start = 1'b0;
    nib_valid   = 1'b0;
    nib_in      = '0;
    word_ready  = 1'b0;
    clr_flags   = 1'b0;
    @(posedge data_clk);
    #1;
    rst_n = 1'b1;
    mq.delete();
    m_nibs.delete();
    m_active = 1'b0;
    m_ch     = 0;
    m_ferr   = 1'b0;
    m_ovf    = 1'b0;
  endtask

  // One clock cycle: drive inputs, compare outputs against the model, then
  // advance the model by the edge that is about to happen.
  task automatic cycle(input bit fs, input bit nv, input logic [3:0] nib,
                       input bit rdy, input bit clr);
    sample_t     s;
    bit          push;
    bit          pop;
    bit          ferr_set;
    bit          ovf_set;
    logic [15:0] w;
    int          ch;
    frame_start = fs;
    nib_valid   = nv;
    nib_in      = nib;
    word_ready  = rdy;
    clr_flags   = clr;
    #4;
    chk("word_valid", 32'(word_valid), 32'(mq.size() > 0));
    chk("fifo_level", 32'(fifo_level), 32'(mq.size()));
    chk("frame_err",  32'(frame_err),  32'(m_ferr));
    chk("overflow",   32'(overflow),   32'(m_ovf));
    if (mq.size() > 0) begin
      chk("word_data", 32'(word_data), 32'(mq[0].data));
      chk("word_ch",   32'(word_ch),   32'(mq[0].ch));
    end

    push = 1'b0; pop = 1'b0; ferr_set = 1'b0; ovf_set = 1'b0;
    w = '0; ch = 0;
    if (fs) begin
      ferr_set = m_active;
      m_active = 1'b1;
      m_nibs.delete();
      m_ch = 0;
    end else if (m_active && nv) begin
      m_nibs.push_back(int'(nib));
      if (m_nibs.size() == 4) begin
        w    = 16'((m_nibs[0] << 12) | (m_nibs[1] << 8) | (m_nibs[2] << 4) | m_nibs[3]);
        push = 1'b1;
        ch   = m_ch;
        m_nibs.delete();
        m_ch++;
        if (m_ch == NUM_CH) m_active = 1'b0;
      end
    end
    pop = (mq.size() > 0) && rdy;
    if (pop) void'(mq.pop_front());
    if (push) begin
      if (mq.size() < FIFO_DEPTH) begin
        s.ch   = 4'(ch);
        s.data = w;
        mq.push_back(s);
      end else begin
        ovf_set = 1'b1;
      end
    end
    if (ferr_set) m_ferr = 1'b1; else if (clr) m_ferr = 1'b0;
    if (ovf_set)  m_ovf  = 1'b1; else if (clr) m_ovf  = 1'b0;

    @(posedge data_clk);
    #1;
  endtask

  task automatic nib(input logic [3:0] n, input bit rdy);
    cycle(1'b0, 1'b1, n, rdy, 1'b0);
  endtask

  logic [15:0] nom_words [4];
  int          drain_ch  [3];

  initial begin
    nom_words = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
    drain_ch  = '{2, 3, 1};

    // Reset state
    do_reset();
    do_reset();
    chk("rst_valid", 32'(word_valid), 0);
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_ferr",  32'(frame_err),  0);
    chk("rst_ovf",   32'(overflow),   0);
    chk("rst_data",  32'(word_data),  0);
    chk("rst_ch",    32'(word_ch),    0);

    // nib_valid before any frame_start is ignored
    for (int i = 0; i < 6; i++) nib(4'($urandom), 1'b1);
    chk("idle_level", 32'(fifo_level), 0);
    chk("idle_valid", 32'(word_valid), 0);

    // Nominal frame: nibbles 1,2,3,... continuous, consumer always ready
    cycle(1'b1, 1'b0, 4'h0, 1'b1, 1'b0);
    for (int i = 0; i < 32; i++) begin
      nib(4'(i + 1), 1'b1);
      if (i % 4 == 3) begin
        chk("nom_valid", 32'(word_valid), 1);
        chk("nom_data",  32'(word_data),  32'(nom_words[(i / 4) % 4]));
        chk("nom_ch",    32'(word_ch),    32'(i / 4));
      end
    end
    cycle(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    // Frame complete: further nibbles must not produce words
    for (int i = 0; i < 4; i++) nib(4'($urandom), 1'b1);
    chk("post_frame_level", 32'(fifo_level), 0);
    chk("post_frame_ferr",  32'(frame_err),  0);

    // Framing error: 6 nibbles then a restart
    cycle(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) nib(4'(10 + i), 1'b0);
    cycle(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    chk("ferr_set",   32'(frame_err),  1);
    chk("ferr_level", 32'(fifo_level), 1);
    chk("ferr_ch0",   32'(word_ch),    0);
    chk("ferr_data0", 32'(word_data),  32'h0000ABCD);
    for (int i = 0; i < 4; i++) nib(4'(i + 1), 1'b0);
    chk("ferr_level2", 32'(fifo_level), 2);
    cycle(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    chk("restart_ch",   32'(word_ch),   0);
    chk("restart_data", 32'(word_data), 32'h00001234);

    // frame_start together with nib_valid: the nibble is discarded
    cycle(1'b1, 1'b1, 4'h9, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) nib(4'(5 + i), 1'b0);
    chk("fs_nib_ch",   32'(word_ch),   0);
    chk("fs_nib_data", 32'(word_data), 32'h00005678);
    cycle(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
    chk("clr_ferr",  32'(frame_err),  0);
    chk("clr_level", 32'(fifo_level), 0);

    // Overflow: full frame with the consumer stalled
    do_reset();
    cycle(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    for (int i = 0; i < 32; i++) nib(4'($urandom), 1'b0);
    chk("ovf_level", 32'(fifo_level), 4);
    chk("ovf_set",   32'(overflow),   1);
    chk("ovf_head",  32'(word_ch),    0);
    // New drop coinciding with clr_flags: overflow stays set
    cycle(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) nib(4'($urandom), 1'b0);
    cycle(1'b0, 1'b1, 4'($urandom), 1'b0, 1'b1);
    chk("ovf_clr_race", 32'(overflow), 1);
    cycle(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
    chk("ovf_clr", 32'(overflow), 0);
    // Push at full together with a pop: accepted, level holds, no overflow
    for (int i = 0; i < 3; i++) nib(4'($urandom), 1'b0);
    cycle(1'b0, 1'b1, 4'($urandom), 1'b1, 1'b0);
    chk("full_pp_level", 32'(fifo_level), 4);
    chk("full_pp_ovf",   32'(overflow),   0);
    chk("full_pp_head",  32'(word_ch),    1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
      chk("drain_ch", 32'(word_ch), 32'(drain_ch[i]));
    end
    cycle(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    chk("drain_empty", 32'(word_valid), 0);

    // Random traffic: stalled-heavy first half, then mostly ready
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      cycle(($urandom_range(0, 99) == 0),
            1'($urandom),
            4'($urandom),
            (i < 1000) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 59) == 0));
    end

    // Reset mid-frame with three words queued and frame_err set
    do_reset();
    cycle(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) nib(4'($urandom), 1'b0);
    cycle(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) nib(4'($urandom), 1'b0);
    chk("pre_rst_level", 32'(fifo_level), 3);
    chk("pre_rst_ferr",  32'(frame_err),  1);
    do_reset();
    chk("mid_rst_level", 32'(fifo_level), 0);
    chk("mid_rst_valid", 32'(word_valid), 0);
    chk("mid_rst_ferr",  32'(frame_err),  0);
    chk("mid_rst_ovf",   32'(overflow),   0);
    cycle(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) nib(4'(i + 1), 1'b0);
    chk("post_rst_ch",    32'(word_ch),    0);
    chk("post_rst_data",  32'(word_data),  32'h00001234);
    chk("post_rst_level", 32'(fifo_level), 1);
    cycle(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_eeg_nibble_packer
